// File: rtl/ins_queue_mp_pkg.sv
// Shared widths and lane-count definitions for the multi-port instruction queue.
package ins_queue_mp_pkg;
  localparam int INS_LEN   = 32;
  localparam int PC_LEN    = 32;
  localparam int LANE_W    = 2;
  localparam int MAX_LANES = 2;

  typedef logic [LANE_W-1:0] lane_cnt_t;

  localparam lane_cnt_t LANES_0 = 2'd0;
  localparam lane_cnt_t LANES_1 = 2'd1;
  localparam lane_cnt_t LANES_2 = 2'd2;

  // A lane count above MAX_LANES is illegal and collapses to zero lanes.
  function automatic lane_cnt_t legal_lanes(input lane_cnt_t n);
    return (n > lane_cnt_t'(MAX_LANES)) ? LANES_0 : n;
  endfunction
endpackage

// File: rtl/ins_queue_mem.sv
// Queue storage: 2 write ports, 2 asynchronous read ports, contents never reset.
module ins_queue_mem
  import ins_queue_mp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = INS_LEN + PC_LEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  logic [W-1:0]  wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [W-1:0]  wdata1,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  rdata0,
  output logic [W-1:0]  rdata1
);
  logic [W-1:0] mem [DEPTH];

  // Both write addresses are always distinct (tail, tail+1 with DEPTH >= 4).
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
endmodule

// File: rtl/ins_queue_mp.sv
// Dual-push / dual-pop show-ahead instruction queue between fetch and dual-issue decode.
module ins_queue_mp
  import ins_queue_mp_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int INS_W    = INS_LEN,
  parameter int PC_W     = PC_LEN,
  parameter int AFULL_TH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ready,
  input  logic                     flush,
  input  logic [1:0]               push_cnt,
  input  logic [INS_W-1:0]         push_ins0,
  input  logic [INS_W-1:0]         push_ins1,
  input  logic [PC_W-1:0]          push_pc0,
  input  logic [PC_W-1:0]          push_pc1,
  output logic                     push_ok,
  input  logic [1:0]               pop_cnt,
  output logic [1:0]               out_valid,
  output logic [INS_W-1:0]         out_ins0,
  output logic [INS_W-1:0]         out_ins1,
  output logic [PC_W-1:0]          out_pc0,
  output logic [PC_W-1:0]          out_pc1,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]        head, tail;
  lane_cnt_t            push_lanes;
  logic [CW-1:0]        push_n, pop_eff, room, cnt_nxt;
  logic [INS_W+PC_W-1:0] rd0, rd1;

  always_comb begin
    push_lanes = legal_lanes(push_cnt);
    push_n     = CW'(push_lanes);
    pop_eff    = (CW'(pop_cnt) > count) ? count : CW'(pop_cnt);
    // Entries retired this cycle count as free space for this cycle's push.
    room       = DEPTH_C - count + pop_eff;
    push_ok    = reset_n && ready && !flush && (push_n != '0) && (push_n <= room);
    cnt_nxt    = count - pop_eff + (push_ok ? push_n : '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else if (ready) begin
      if (flush) begin
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        empty       <= 1'b1;
        full        <= 1'b0;
        almost_full <= 1'b0;
      end else begin
        head        <= head + pop_eff[AW-1:0];
        if (push_ok) tail <= tail + push_n[AW-1:0];
        count       <= cnt_nxt;
        empty       <= (cnt_nxt == '0);
        full        <= (cnt_nxt == DEPTH_C);
        almost_full <= (int'(DEPTH_C - cnt_nxt) < AFULL_TH);
      end
    end
  end

  ins_queue_mem #(
    .DEPTH (DEPTH),
    .W     (INS_W + PC_W),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .we0    (push_ok),
    .waddr0 (tail),
    .wdata0 ({push_ins0, push_pc0}),
    .we1    (push_ok && (push_lanes == LANES_2)),
    .waddr1 (tail + AW'(1)),
    .wdata1 ({push_ins1, push_pc1}),
    .raddr0 (head),
    .raddr1 (head + AW'(1)),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  assign {out_ins0, out_pc0} = rd0;
  assign {out_ins1, out_pc1} = rd1;
  assign out_valid = {count >= CW'(2), count != '0};
endmodule

// File: tb/tb_ins_queue_mp.sv
// Bench for ins_queue_mp: directed vector table plus random traffic against a queue model.
module tb_ins_queue_mp;
  import ins_queue_mp_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0, ready = 1'b0, flush = 1'b0;
  logic [1:0]  push_cnt = '0, pop_cnt = '0;
  logic [31:0] push_ins0 = '0, push_ins1 = '0, push_pc0 = '0, push_pc1 = '0;
  logic        push_ok;
  logic [1:0]  out_valid;
  logic [31:0] out_ins0, out_ins1, out_pc0, out_pc1;
  logic [4:0]  count;
  logic        empty, full, almost_full;

  always #5 clk = ~clk;

  ins_queue_mp #(.DEPTH(DEPTH), .INS_W(32), .PC_W(32), .AFULL_TH(AF)) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .flush(flush),
    .push_cnt(push_cnt), .push_ins0(push_ins0), .push_ins1(push_ins1),
    .push_pc0(push_pc0), .push_pc1(push_pc1), .push_ok(push_ok),
    .pop_cnt(pop_cnt), .out_valid(out_valid),
    .out_ins0(out_ins0), .out_ins1(out_ins1), .out_pc0(out_pc0), .out_pc1(out_pc1),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       fl;
    logic [1:0] pc;
    logic [1:0] pp;
    logic       ok;
    int         cnt;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          seq = 0;
  logic        inited = 1'b0;
  logic        last_ok;
  logic [63:0] q[$];
  vec_t        v[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_state();
    int sz;
    sz = q.size();
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("almost_full", 64'(almost_full), 64'((DEPTH - sz) < AF));
    chk("out_valid", 64'(out_valid), 64'({sz >= 2, sz >= 1}));
    if (sz >= 1) chk("head0", {out_ins0, out_pc0}, q[0]);
    if (sz >= 2) chk("head1", {out_ins1, out_pc1}, q[1]);
  endtask

  task automatic apply(input logic rst, input logic rdy, input logic fl,
                       input logic [1:0] pc, input logic [1:0] pp);
    int   sz, pe, pn;
    logic ok;
    @(negedge clk);
    reset_n = rst; ready = rdy; flush = fl; push_cnt = pc; pop_cnt = pp;
    push_ins0 = 32'h13 | 32'(seq << 12);
    push_pc0  = 32'(seq * 4);
    push_ins1 = 32'h13 | 32'((seq + 1) << 12);
    push_pc1  = 32'((seq + 1) * 4);
    seq += 2;
    sz = q.size();
    pe = (int'(pp) > sz) ? sz : int'(pp);
    pn = (pc == 2'd3) ? 0 : int'(pc);
    ok = rdy && !fl && (pn != 0) && (pn <= DEPTH - sz + pe);
    #1;
    last_ok = push_ok;
    if (rst) chk("push_ok", 64'(push_ok), 64'(ok));
    // Nothing pushed this cycle may show up before the edge.
    if (inited) chk("pre_valid", 64'(out_valid), 64'({sz >= 2, sz >= 1}));
    @(posedge clk);
    if (!rst || (rdy && fl)) q.delete();
    else if (rdy) begin
      repeat (pe) void'(q.pop_front());
      if (ok) begin
        q.push_back({push_ins0, push_pc0});
        if (pn == 2) q.push_back({push_ins1, push_pc1});
      end
    end
    if (!rst) inited = 1'b1;
    #1;
    if (inited) check_state();
  endtask

  task automatic add(input logic rst, input logic rdy, input logic fl, input logic [1:0] pc,
                     input logic [1:0] pp, input logic ok, input int cnt);
    v.push_back('{rst: rst, rdy: rdy, fl: fl, pc: pc, pp: pp, ok: ok, cnt: cnt});
  endtask

  initial begin
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 0, 2, 0, 1, 2 * (i + 1));
    add(1, 1, 0, 1, 0, 0, 16);
    add(1, 1, 0, 2, 2, 1, 16);
    add(1, 1, 0, 1, 1, 1, 16);
    add(1, 1, 0, 3, 0, 0, 16);
    for (int i = 0; i < 7; i++) add(1, 1, 0, 0, 2, 0, 14 - 2 * i);
    add(1, 1, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 2, 0, 0);
    add(1, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 2, 0, 1, 3);
    add(1, 1, 0, 2, 0, 1, 5);
    add(1, 1, 1, 2, 1, 0, 0);
    add(1, 1, 0, 1, 0, 1, 1);
    add(1, 1, 0, 2, 0, 1, 3);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 2, 2, 0, 3);
    add(0, 0, 0, 2, 2, 0, 0);
    add(1, 1, 0, 3, 1, 0, 0);

    for (int i = 0; i < v.size(); i++) begin
      apply(v[i].rst, v[i].rdy, v[i].fl, v[i].pc, v[i].pp);
      if (v[i].rst) chk($sformatf("vec%0d_ok", i), 64'(last_ok), 64'(v[i].ok));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(v[i].cnt));
    end

    // Wrap check: after filling, a 2-for-2 swap must expose the third-oldest PC at the head.
    apply(1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) apply(1, 1, 0, 2, 0);
    begin
      logic [31:0] third_pc;
      third_pc = q[2][31:0];
      apply(1, 1, 0, 2, 2);
      chk("wrap_pc0", 64'(out_pc0), 64'(third_pc));
    end

    for (int i = 0; i < 800; i++) begin
      apply(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 7) != 0),
            logic'($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
